muldiv_seq: RTL and testbench



---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/add_sub.sv | 17 +
 rtl/muldiv_seq.sv | 155 +++++++++++++++
 tb/tb_muldiv_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
      ST_DONE
   } muldiv_state_e;

   localparam int MULDIV_STEPS = 32;
   localparam int MULDIV_CNT_W = 5;

   function automatic logic op_signed_a(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_signed_b(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/add_sub.sv
// Ripple-style adder/subtractor: i_sub=1 computes i_a - i_b via inverted b and carry-in.
module add_sub #(
   parameter int WIDTH = 33
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sub,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);

   logic [WIDTH-1:0] b_eff;

   assign b_eff = i_b ^ {WIDTH{i_sub}};
   assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, i_sub};

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply / restoring divide on one adder.
// Optional MULDIV_FAST_ZERO_EN: divide-by-zero, signed overflow and zero-operand multiply skip CALC.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [2:0]       i_muldiv_op,
   input  logic [WIDTH-1:0] i_operand_a,
   input  logic [WIDTH-1:0] i_operand_b,
   output logic             o_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result
);

`ifdef MULDIV_FAST_ZERO_EN
   localparam bit FAST_ZERO = 1'b1;
`else
   localparam bit FAST_ZERO = 1'b0;
`endif

   localparam int AW = WIDTH + 1;
   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   muldiv_state_e           state_q, state_d;
   logic [MULDIV_CNT_W-1:0] cnt_q;
   muldiv_op_e              op_q;
   logic [WIDTH-1:0]        hi_q, lo_q, b_q, a_q, result_q;
   logic                    neg_a_q, neg_res_q, div_zero_q, ovf_q, mul_zero_q;

   // Decode of the incoming request, used only at acceptance
   muldiv_op_e       op_in;
   logic             neg_a_in, neg_b_in, div_zero_in, ovf_in, mul_zero_in, special_in;
   logic [WIDTH-1:0] mag_a_in, mag_b_in;
   logic             accept, last_step;

   assign op_in       = muldiv_op_e'(i_muldiv_op);
   assign neg_a_in    = op_signed_a(op_in) & i_operand_a[WIDTH-1];
   assign neg_b_in    = op_signed_b(op_in) & i_operand_b[WIDTH-1];
   assign mag_a_in    = neg_a_in ? -i_operand_a : i_operand_a;
   assign mag_b_in    = neg_b_in ? -i_operand_b : i_operand_b;
   assign div_zero_in = i_muldiv_op[2] && (i_operand_b == '0);
   assign ovf_in      = op_signed_b(op_in) && i_muldiv_op[2] &&
                        (i_operand_a == INT_MIN) && (i_operand_b == '1);
   assign mul_zero_in = !i_muldiv_op[2] && ((i_operand_a == '0) || (i_operand_b == '0));
   assign special_in  = div_zero_in | ovf_in | mul_zero_in;

   assign accept    = (state_q == ST_IDLE) && i_start;
   assign last_step = (cnt_q == MULDIV_CNT_W'(MULDIV_STEPS - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (i_start) state_d = (FAST_ZERO && special_in) ? ST_FIX : ST_CALC;
         ST_CALC: if (last_step) state_d = ST_FIX;
         ST_FIX:  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign o_ready  = (state_q == ST_IDLE);
   assign o_busy   = (state_q != ST_IDLE);
   assign o_done   = (state_q == ST_DONE);
   assign o_result = result_q;

   // Shared step: multiply adds the multiplicand to the high half when the
   // multiplier LSB is set; divide trial-subtracts the divisor from the shifted remainder.
   logic          is_div;
   logic [AW-1:0] add_a, add_b, add_sum;
   logic          add_cout;

   assign is_div = op_q[2];
   assign add_a  = is_div ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
   assign add_b  = (is_div || lo_q[0]) ? {1'b0, b_q} : '0;

   add_sub #(.WIDTH(AW)) u_add_sub (
      .i_a    (add_a),
      .i_b    (add_b),
      .i_sub  (is_div),
      .o_sum  (add_sum),
      .o_cout (add_cout)
   );

   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix, fix_res;

   assign prod     = {hi_q, lo_q};
   assign prod_fix = neg_res_q ? -prod : prod;
   assign quot_fix = neg_res_q ? -lo_q : lo_q;
   assign rem_fix  = neg_a_q ? -hi_q : hi_q;

   always_comb begin
      fix_res = '0;
      if (is_div) begin
         if (div_zero_q)  fix_res = op_q[1] ? a_q : '1;
         else if (ovf_q)  fix_res = op_q[1] ? '0 : INT_MIN;
         else             fix_res = op_q[1] ? rem_fix : quot_fix;
      end else if (!mul_zero_q) begin
         fix_res = (op_q == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q      <= '0;
         op_q       <= OP_MUL;
         hi_q       <= '0;
         lo_q       <= '0;
         b_q        <= '0;
         a_q        <= '0;
         neg_a_q    <= 1'b0;
         neg_res_q  <= 1'b0;
         div_zero_q <= 1'b0;
         ovf_q      <= 1'b0;
         mul_zero_q <= 1'b0;
         result_q   <= '0;
      end else begin
         if (accept) begin
            cnt_q      <= '0;
            op_q       <= op_in;
            hi_q       <= '0;
            lo_q       <= mag_a_in;
            b_q        <= mag_b_in;
            a_q        <= i_operand_a;
            neg_a_q    <= neg_a_in;
            neg_res_q  <= neg_a_in ^ neg_b_in;
            div_zero_q <= div_zero_in;
            ovf_q      <= ovf_in;
            mul_zero_q <= mul_zero_in;
         end else if (state_q == ST_CALC) begin
            cnt_q <= cnt_q + MULDIV_CNT_W'(1);
            if (is_div) begin
               // Restore on borrow: keep the shifted remainder, quotient bit 0
               hi_q <= add_cout ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
               lo_q <= {lo_q[WIDTH-2:0], add_cout};
            end else begin
               hi_q <= add_sum[AW-1:1];
               lo_q <= {add_sum[0], lo_q[WIDTH-1:1]};
            end
         end
         if (state_q == ST_FIX) result_q <= fix_res;
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: driver pushes reference results, monitor pops on o_done.
module tb_muldiv_seq;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_start;
   logic [2:0]  i_muldiv_op;
   logic [31:0] i_operand_a, i_operand_b;
   logic        o_ready, o_busy, o_done;
   logic [31:0] o_result;

   muldiv_seq #(.WIDTH(32)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_muldiv_op (i_muldiv_op),
      .i_operand_a (i_operand_a),
      .i_operand_b (i_operand_b),
      .o_ready     (o_ready),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_result    (o_result)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] res;
      int          due;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] last_res = '0;
   bit          ready_due = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: RISC-V M semantics written with plain 64-bit arithmetic
   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      longint      sx = longint'($signed(x));
      longint      sy = longint'($signed(y));
      longint      ux = longint'({32'b0, x});
      logic [63:0] pu = {32'b0, x} * {32'b0, y};
      longint      p;
      bit          ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      case (op)
         3'd0: return pu[31:0];
         3'd1: begin p = sx * sy; return p[63:32]; end
         3'd2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
         3'd3: return pu[63:32];
         3'd4: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (ovf)    return 32'h8000_0000;
            return $signed(x) / $signed(y);
         end
         3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: begin
            if (y == 0) return x;
            if (ovf)    return 32'h0;
            return $signed(x) % $signed(y);
         end
         default: return (y == 0) ? x : x % y;
      endcase
      if (ux < 0) return '0;
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      bit special;
      special = op[2] ? ((y == 0) || (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))
                      : ((x == 0) || (y == 0));
`ifdef MULDIV_FAST_ZERO_EN
      if (special) return 1;
`else
      if (special) return 33;
`endif
      return 33;
   endfunction

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(7, 0))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(20, 0));
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge after the acceptance edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      int n = 0;
      while (!o_ready && n < 100) begin
         @(negedge i_clk);
         n++;
      end
      if (!o_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: o_ready=%b expected 1", o_ready);
         return;
      end
      chk("result_hold", o_result, last_res);
      i_start     = 1'b1;
      i_muldiv_op = op;
      i_operand_a = x;
      i_operand_b = y;
      @(negedge i_clk);
      i_start     = 1'b0;
      i_muldiv_op = 3'($urandom);
      i_operand_a = $urandom;
      i_operand_b = $urandom;
      sb.push_back('{ref_res(op, x, y), cyc + exp_lat(op, x, y)});
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (ready_due) begin
            chk("ready_after_done", {31'b0, o_ready}, 32'd1);
            ready_due = 1'b0;
         end
         if (!i_rst && o_done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done: o_done=1 expected 0 (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               chk("result", o_result, e.res);
               chk("done_cycle", 32'(cyc), 32'(e.due));
               last_res  = e.res;
               ready_due = 1'b1;
            end
         end
      end
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } vec_t;

   vec_t dir[$] = '{
      '{3'd0, 32'd7,          32'hFFFF_FFFD},
      '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
      '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
      '{3'd2, 32'hFFFF_FFFF,  32'd2},
      '{3'd4, 32'hFFFF_FFF9,  32'd2},
      '{3'd6, 32'hFFFF_FFF9,  32'd2},
      '{3'd5, 32'd100,        32'd7},
      '{3'd7, 32'd100,        32'd7},
      '{3'd5, 32'd5,          32'd0},
      '{3'd7, 32'd5,          32'd0},
      '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF},
      '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF},
      '{3'd4, 32'hFFFF_FFFB,  32'd0},
      '{3'd6, 32'hFFFF_FFFB,  32'd0},
      '{3'd0, 32'd0,          32'h1234_5678},
      '{3'd1, 32'h8000_0000,  32'h8000_0000}
   };

   // Driver
   initial begin
      int dn;
      int n;
      i_rst       = 1'b1;
      i_start     = 1'b0;
      i_muldiv_op = '0;
      i_operand_a = '0;
      i_operand_b = '0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      chk("rst_ready",  {31'b0, o_ready}, 32'd1);
      chk("rst_busy",   {31'b0, o_busy},  32'd0);
      chk("rst_done",   {31'b0, o_done},  32'd0);
      chk("rst_result", o_result,         32'd0);

      foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b);

      for (int k = 0; k < 60; k++) begin
         issue(3'($urandom), rand_opnd(), rand_opnd());
         if ($urandom_range(1, 0) == 1) begin
            repeat ($urandom_range(25, 1)) @(negedge i_clk);
            if (!o_ready) begin
               i_start     = 1'b1;
               i_muldiv_op = 3'($urandom);
               i_operand_a = $urandom;
               i_operand_b = $urandom;
               @(negedge i_clk);
               i_start = 1'b0;
            end
         end
      end

      // Drain, then abort a DIV with reset after an ignored mid-run start
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      chk("drain_before_abort", 32'(sb.size()), 32'd0);
      while (!o_ready && n < 300) begin
         @(negedge i_clk);
         n++;
      end
      i_start     = 1'b1;
      i_muldiv_op = 3'd4;
      i_operand_a = 32'd1000;
      i_operand_b = 32'd3;
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (4) @(negedge i_clk);
      i_start     = 1'b1;
      i_muldiv_op = 3'd0;
      i_operand_a = 32'd9;
      i_operand_b = 32'd9;
      @(negedge i_clk);
      i_start = 1'b0;
      chk("busy_mid_run", {31'b0, o_busy}, 32'd1);
      repeat (4) @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      chk("abort_ready",  {31'b0, o_ready}, 32'd1);
      chk("abort_busy",   {31'b0, o_busy},  32'd0);
      chk("abort_done",   {31'b0, o_done},  32'd0);
      chk("abort_result", o_result,         32'd0);
      last_res = '0;
      dn = 0;
      repeat (40) begin
         @(negedge i_clk);
         if (o_done) dn++;
      end
      chk("no_done_after_abort", 32'(dn), 32'd0);

      // One more operation after the abort to confirm recovery
      issue(3'd5, 32'd100, 32'd7);
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge i_clk);
         n++;
      end
      chk("final_drain", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
